// File: rtl/mem_subword_ctrl.sv
// Load/store sequencer between the CPU datapath and a word-wide synchronous RAM.
// Sub-word loads extract and extend a lane; sub-word stores do read-modify-write.
module mem_subword_ctrl #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        mode,
  input  logic              signext,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              done,
  output logic              misalign,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_LAT, S_WR, S_DONE} state_t;

  state_t              r_state;
  logic                r_we;
  logic                r_sx;
  logic                r_mis;
  logic [1:0]          r_mode;
  logic [ADDR_W+1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_wbuf;
  logic [31:0]         r_rdata;
  logic                w_mis;
  logic                w_unused_addr;

  // Bits above the RAM's reach are ignored so accesses wrap modulo RAM depth.
  assign w_unused_addr = ^addr[31:ADDR_W+2];

  assign w_mis = ((mode == 2'b01) && addr[0]) || (mode[1] && (addr[1:0] != 2'b00));

  function automatic logic [31:0] f_extract(input logic [1:0] m, input logic sx,
                                            input logic [1:0] lo, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = lo[1] ? d[31:16] : d[15:0];
    case (m)
      2'b00:   f_extract = {{24{sx & b[7]}}, b};
      2'b01:   f_extract = {{16{sx & h[15]}}, h};
      default: f_extract = d;
    endcase
  endfunction

  function automatic logic [31:0] f_merge(input logic [1:0] m, input logic [1:0] lo,
                                          input logic [31:0] d, input logic [31:0] w);
    f_merge = d;
    if (m == 2'b00) begin
      case (lo)
        2'd0:    f_merge[7:0]   = w[7:0];
        2'd1:    f_merge[15:8]  = w[7:0];
        2'd2:    f_merge[23:16] = w[7:0];
        default: f_merge[31:24] = w[7:0];
      endcase
    end else if (m == 2'b01) begin
      if (lo[1]) f_merge[31:16] = w[15:0];
      else       f_merge[15:0]  = w[15:0];
    end else begin
      f_merge = w;
    end
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_sx    <= 1'b0;
      r_mis   <= 1'b0;
      r_mode  <= 2'b00;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wbuf  <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_we    <= we;
            r_mode  <= mode;
            r_sx    <= signext;
            r_addr  <= addr[ADDR_W+1:0];
            r_wdata <= wdata;
            r_mis   <= w_mis;
            r_rdata <= '0;
            if (w_mis) begin
              r_state <= S_DONE;
            end else if (we && mode[1]) begin
              r_wbuf  <= wdata;
              r_state <= S_WR;
            end else begin
              r_state <= S_RD;
            end
          end
        end
        S_RD:  r_state <= S_LAT;
        S_LAT: begin
          // RAM data for the word presented in RD is valid here.
          if (r_we) begin
            r_wbuf  <= f_merge(r_mode, r_addr[1:0], ram_rdata, r_wdata);
            r_state <= S_WR;
          end else begin
            r_rdata <= f_extract(r_mode, r_sx, r_addr[1:0], ram_rdata);
            r_state <= S_DONE;
          end
        end
        S_WR:    r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Stall covers the request cycle itself so the CPU holds its operands.
  assign stall     = ((r_state == S_IDLE) && req) || (r_state == S_RD) ||
                     (r_state == S_LAT) || (r_state == S_WR);
  assign done      = (r_state == S_DONE);
  assign misalign  = done & r_mis;
  assign rdata     = done ? r_rdata : 32'h0;
  assign ram_addr  = r_addr[ADDR_W+1:2];
  assign ram_we    = (r_state == S_WR);
  assign ram_wdata = r_wbuf;

endmodule
